// File: rtl/latch_bank_arbiter.sv
// rtl/latch_bank_arbiter.sv - round-robin arbiter sequencing writes into one shared D-latch
// Each write runs SETUP/ENABLE/HOLD/DONE and verifies the latch contents by readback.
module latch_bank_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 8,
    parameter int EN_CYCLES   = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic [DW-1:0]      latch_q,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               latch_en,
    output logic [DW-1:0]      latch_d,
    output logic               busy,
    output logic               err
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ENABLE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;
    logic            pick_valid;

    // Scan from the highest offset down so the nearest request at/after ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = PW'((int'(ptr) + off) % NREQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            latch_en <= 1'b0;
            latch_d  <= '0;
            err      <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt     <= NREQ'(1) << pick_idx;
                        latch_d <= wdata[pick_idx*DW +: DW];
                        ptr     <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    latch_en <= 1'b1;
                    cnt      <= CW'(EN_CYCLES - 1);
                    state    <= ENABLE;
                end
                ENABLE: begin
                    if (cnt == '0) begin
                        latch_en <= 1'b0;
                        cnt      <= CW'(HOLD_CYCLES - 1);
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        // err is sticky: only reset clears it
                        if (latch_q != latch_d)
                            err <= 1'b1;
                        ack   <= gnt;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt      <= '0;
                    latch_en <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb/tb_latch_bank_arbiter.sv - scoreboard bench for latch_bank_arbiter
module tb_latch_bank_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int ENC  = 2;
    localparam int HLD  = 1;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]      latch_q;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               latch_en;
    logic [DW-1:0]      latch_d;
    logic               busy;
    logic               err;

    latch_bank_arbiter #(
        .NREQ(NREQ), .DW(DW), .EN_CYCLES(ENC), .HOLD_CYCLES(HLD)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .wdata(wdata), .latch_q(latch_q),
        .gnt(gnt), .ack(ack), .latch_en(latch_en), .latch_d(latch_d),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    // Shared latch model with a stuck-at-zero fault switch.
    logic [DW-1:0] latch_mem = '0;
    logic          stuck = 1'b0;
    always_latch if (latch_en) latch_mem = latch_d;
    assign latch_q = stuck ? '0 : latch_mem;

    typedef struct {
        int            idx;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
        logic          e;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   en_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.idx = idx;
        x.d   = d;
        x.q   = stuck ? '0 : d;
        x.e   = e;
        sb.push_back(x);
    endtask

    always @(negedge clock) begin
        exp_t x;
        if (!reset) begin
            cyc    = 0;
            en_cnt = 0;
        end else begin
            check("gnt_onehot", 32'($onehot0(gnt)), 1);
            check("ack_onehot", 32'($onehot0(ack)), 1);
            if (latch_en)
                check("en_outside_write", 32'(gnt != '0), 1);
            if (gnt == '0) begin
                cyc    = 0;
                en_cnt = 0;
            end else begin
                cyc++;
                if (latch_en) en_cnt++;
            end
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    check("spurious_ack", 32'(ack), 0);
                end else begin
                    x = sb.pop_front();
                    check("ack_idx", 32'(ack), 32'(1) << x.idx);
                    check("gnt_at_ack", 32'(gnt), 32'(ack));
                    check("latch_d", 32'(latch_d), 32'(x.d));
                    check("latch_q", 32'(latch_q), 32'(x.q));
                    check("err", 32'(err), 32'(x.e));
                    check("latency", 32'(cyc), 32'(2 + ENC + HLD));
                    check("en_cycles", 32'(en_cnt), 32'(ENC));
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int b = budget;
        while (sb.size() != 0 && b > 0) begin
            @(negedge clock);
            #1;
            b--;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_en", 32'(latch_en), 0);
        check("rst_d", 32'(latch_d), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        reset = 1'b1;
        @(negedge clock);
        #1;
    endtask

    initial begin
        int b;
        req   = '0;
        wdata = '0;
        reset = 1'b1;
        #2;

        // T1: reset, then idle with no requests
        do_reset();
        repeat (3) @(negedge clock);
        check("idle_busy", 32'(busy), 0);
        check("idle_gnt", 32'(gnt), 0);
        check("idle_en", 32'(latch_en), 0);

        // T2: single write
        wdata[7:0] = 8'hA5;
        push(0, 8'hA5, 1'b0);
        req = 4'b0001;
        wait_drain(50);
        req = '0;
        repeat (2) @(negedge clock);
        check("t2_latch", 32'(latch_q), 32'h A5);

        // T3: all requesting, round-robin 0,1,2,3,0
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        push(0, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(2, 8'h33, 1'b0);
        push(3, 8'h44, 1'b0);
        push(0, 8'h11, 1'b0);
        req = 4'b1111;
        wait_drain(100);
        req = '0;
        @(negedge clock);

        // T4: stuck latch sets sticky err; later good write keeps it
        stuck = 1'b1;
        wdata[7:0] = 8'h3C;
        push(0, 8'h3C, 1'b1);
        req = 4'b0001;
        wait_drain(50);
        req = '0;
        stuck = 1'b0;
        @(negedge clock);
        wdata[15:8] = 8'h5A;
        push(1, 8'h5A, 1'b1);
        req = 4'b0010;
        wait_drain(50);
        req = '0;
        @(negedge clock);
        check("t4_err_sticky", 32'(err), 1);
        do_reset();

        // T5: reset during ENABLE aborts the write
        wdata = {8'h04, 8'h03, 8'h77, 8'h66};
        req = 4'b0001;
        b = 20;
        while (!latch_en && b > 0) begin
            @(negedge clock);
            #1;
            b--;
        end
        check("t5_reach_enable", 32'(latch_en), 1);
        reset = 1'b0;
        #1;
        check("t5_en_drop", 32'(latch_en), 0);
        check("t5_gnt_drop", 32'(gnt), 0);
        check("t5_busy_drop", 32'(busy), 0);
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        // pointer back at 0: requester 0 wins over 1
        push(0, 8'h66, 1'b0);
        push(1, 8'h77, 1'b0);
        req = 4'b0011;
        wait_drain(60);
        req = '0;
        @(negedge clock);

        // T6: req[2] dropped in SETUP still acks; pointer then at 3
        do_reset();
        wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        push(2, 8'hC2, 1'b0);
        req = 4'b0100;
        b = 20;
        while (gnt != 4'b0100 && b > 0) begin
            @(negedge clock);
            #1;
            b--;
        end
        check("t6_gnt2", 32'(gnt), 32'h4);
        req = '0;
        wait_drain(50);
        push(3, 8'hD3, 1'b0);
        push(0, 8'hA0, 1'b0);
        req = 4'b1001;
        wait_drain(60);
        req = '0;
        repeat (3) @(negedge clock);
        check("end_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
